bsg_cache_prefetch_sched: RTL and testbench

Prefetch issue scheduler between the stream prefetcher and the cache DMA engine. It buffers block-aligned prefetch candidates in a small FIFO and drops duplicates and overflow. It then issues candidates one at a time over a valid/yumi handshake, always yielding to demand misses, and enforces a programmable cool-down gap between prefetch issues.

---
 rtl/bsg_cache_prefetch_pkg.sv | 18 +
 rtl/bsg_cache_prefetch_fifo.sv | 71 +++++++
 rtl/bsg_cache_prefetch_sched.sv | 109 ++++++++++
 tb/tb_bsg_cache_prefetch_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_prefetch_pkg.sv
// Shared prefetch definitions: scheduler state encoding and block alignment helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. The stream prefetcher also imports this package.
package bsg_cache_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } pf_state_e;

  // Works on a 64-bit container so callers of any address width up to 64 can share it.
  function automatic logic [63:0] block_align(input logic [63:0] addr,
                                              input int unsigned offset_width);
    return addr & ~((64'd1 << offset_width) - 64'd1);
  endfunction

endpackage

// File: rtl/bsg_cache_prefetch_fifo.sv
// Circular candidate FIFO with a parallel match over its valid entries.
// Latency: push visible at head one cycle later; match_o is combinational on stored state.
// Backpressure: none; caller must only push when not full or when popping in the same cycle.
// Ports: push_i/data_i write, pop_i advances head (data_o), clear_i empties at the next edge,
//        match_data_i/match_o compare against every valid entry, full_o/empty_o status.
module bsg_cache_prefetch_fifo
  import bsg_cache_prefetch_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] match_data_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               match_o
);

  localparam int ptr_w = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rptr;
  logic [ptr_w-1:0]   wptr;
  logic [ptr_w:0]     count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clear_i) begin
      // A push landing with a clear is discarded.
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (pop_i)  rptr <= rptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are qualified by count everywhere they are read.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem[wptr] <= data_i;
  end

  // Entry i is valid when its distance from the head is below the occupancy.
  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (({1'b0, ptr_w'(i) - rptr} < count) && (mem[i] == match_data_i)) match_o = 1'b1;
    end
  end

  assign data_o  = mem[rptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == (ptr_w + 1)'(els_p));

endmodule

// File: rtl/bsg_cache_prefetch_sched.sv
// Prefetch issue scheduler: dedups/queues candidates and issues them to DMA one at a time.
// Latency: candidate sampled at edge N is presented on dma_pf_v_o after edge N+1.
// Backpressure: none toward the prefetcher (overflow is dropped and counted); valid/yumi to DMA.
// Ports: pf_addr_i/pf_v_i candidates, demand_v_i blocks new issue, flush_i empties the queue,
//        gap_i cool-down after each issue, dma_pf_* request handshake, drop_count_o, busy_o.
module bsg_cache_prefetch_sched
  import bsg_cache_prefetch_pkg::*;
#(
  parameter int addr_width_p         = 32,
  parameter int queue_els_p          = 4,
  parameter int block_offset_width_p = 6,
  parameter int gap_width_p          = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] pf_addr_i,
  input  logic                    pf_v_i,
  input  logic                    demand_v_i,
  input  logic                    flush_i,
  input  logic [gap_width_p-1:0]  gap_i,
  output logic [addr_width_p-1:0] dma_pf_addr_o,
  output logic                    dma_pf_v_o,
  input  logic                    dma_pf_yumi_i,
  output logic [7:0]              drop_count_o,
  output logic                    busy_o
);

  pf_state_e               state;
  logic [gap_width_p-1:0]  gap_cnt;
  logic [addr_width_p-1:0] pf_addr_aligned;
  logic [addr_width_p-1:0] fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_match;
  logic                    dup;
  logic                    pop;
  logic                    push;
  logic                    overflow;

  assign pf_addr_aligned = addr_width_p'(block_align(64'(pf_addr_i), block_offset_width_p));

  // The match sees the queue before this cycle's pop; the popped entry moves into the
  // issue register, which is checked separately while the request is live.
  assign dup      = fifo_match || (dma_pf_v_o && (pf_addr_aligned == dma_pf_addr_o));
  assign pop      = (state == IDLE) && !fifo_empty && !demand_v_i && !flush_i;
  assign push     = pf_v_i && !flush_i && !dup && (!fifo_full || pop);
  assign overflow = pf_v_i && !flush_i && !dup && fifo_full && !pop;

  bsg_cache_prefetch_fifo #(
    .width_p (addr_width_p),
    .els_p   (queue_els_p)
  ) fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .data_i       (pf_addr_aligned),
    .pop_i        (pop),
    .clear_i      (flush_i),
    .match_data_i (pf_addr_aligned),
    .data_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .match_o      (fifo_match)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      dma_pf_v_o    <= 1'b0;
      dma_pf_addr_o <= '0;
      gap_cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            dma_pf_addr_o <= fifo_head;
            dma_pf_v_o    <= 1'b1;
            state         <= ISSUE;
          end
        end
        // Once raised, the request is held regardless of demand or flush.
        ISSUE: begin
          if (dma_pf_yumi_i) begin
            dma_pf_v_o <= 1'b0;
            if (gap_i == '0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_i;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == gap_width_p'(1)) state <= IDLE;
          else                            gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                               drop_count_o <= '0;
    else if (overflow && drop_count_o != 8'hff) drop_count_o <= drop_count_o + 1'b1;
  end

  assign busy_o = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_bsg_cache_prefetch_sched.sv
// Bench for the prefetch issue scheduler: directed scenarios followed by random traffic,
// all checked against a timestamp-based queue model with an issue-order scoreboard.
module tb_bsg_cache_prefetch_sched;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] pf_addr_i = '0;
  logic        pf_v_i = 1'b0;
  logic        demand_v_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  gap_i = '0;
  logic [31:0] dma_pf_addr_o;
  logic        dma_pf_v_o;
  logic        dma_pf_yumi_i = 1'b0;
  logic [7:0]  drop_count_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  int n_issued = 0;

  always #5 clk_i = ~clk_i;

  bsg_cache_prefetch_sched dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .pf_addr_i     (pf_addr_i),
    .pf_v_i        (pf_v_i),
    .demand_v_i    (demand_v_i),
    .flush_i       (flush_i),
    .gap_i         (gap_i),
    .dma_pf_addr_o (dma_pf_addr_o),
    .dma_pf_v_o    (dma_pf_v_o),
    .dma_pf_yumi_i (dma_pf_yumi_i),
    .drop_count_o  (drop_count_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pending-candidate queue, one outstanding request, and the earliest edge at which
  // the next pop may happen (yumi edge + gap + 1).
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic        m_v = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_drops = 0;
  int          m_allowed = 0;
  int          m_edge = 0;
  logic        m_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk_i or posedge reset_i);
      if (reset_i) begin
        mq.delete();
        exp_q.delete();
        m_v = 1'b0;
        m_addr = '0;
        m_drops = 0;
        m_allowed = 0;
      end else begin
        logic [31:0] a;
        logic        dup;
        logic        do_pop;
        m_edge++;
        a = pf_addr_i & ~32'h3f;
        dup = m_v && (a == m_addr);
        foreach (mq[i]) if (mq[i] == a) dup = 1'b1;
        do_pop = !m_v && (m_edge >= m_allowed) && (mq.size() > 0) && !demand_v_i && !flush_i;
        if (m_v && dma_pf_yumi_i) begin
          m_v = 1'b0;
          m_allowed = m_edge + 1 + int'(gap_i);
        end else if (do_pop) begin
          m_addr = mq.pop_front();
          m_v = 1'b1;
          exp_q.push_back(m_addr);
        end
        if (flush_i) mq.delete();
        else if (pf_v_i && !dup) begin
          if (mq.size() == DEPTH) begin
            if (m_drops < 255) m_drops++;
          end else begin
            mq.push_back(a);
          end
        end
      end
      m_busy = (mq.size() > 0) || m_v || (m_edge + 1 < m_allowed);
    end
  end

  // ---------------- monitor ----------------
  logic prev_v = 1'b0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        prev_v = 1'b0;
      end else begin
        chk("mon_v", 32'(dma_pf_v_o), 32'(m_v));
        if (m_v) chk("mon_addr", dma_pf_addr_o, m_addr);
        chk("mon_drops", 32'(drop_count_o), 32'(m_drops));
        chk("mon_busy", 32'(busy_o), 32'(m_busy));
        if (dma_pf_v_o && !prev_v) begin
          n_issued++;
          if (exp_q.size() == 0) chk("sb_unexpected_issue", dma_pf_addr_o, 32'hffff_ffff);
          else                   chk("sb_issue_addr", dma_pf_addr_o, exp_q.pop_front());
        end
        prev_v = dma_pf_v_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic pv, input logic [31:0] pa, input logic dem,
                      input logic fl, input logic ack);
    @(negedge clk_i);
    pf_v_i        = pv;
    pf_addr_i     = pa;
    demand_v_i    = dem;
    flush_i       = fl;
    dma_pf_yumi_i = ack & dma_pf_v_o;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int          yumi_edge;
    int          rise_edge;
    int          n_saved;
    logic [31:0] ra;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("reset_v_during", 32'(dma_pf_v_o), 32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("reset_v", 32'(dma_pf_v_o), 32'h0);
    chk("reset_addr", dma_pf_addr_o, 32'h0);
    chk("reset_drops", 32'(drop_count_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);

    // Single candidate: two-cycle latency, aligned address, held until yumi
    step(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("single_not_yet", 32'(dma_pf_v_o), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("single_v", 32'(dma_pf_v_o), 32'h1);
    chk("single_addr", dma_pf_addr_o, 32'h1200);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("single_held", 32'(dma_pf_v_o), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("single_consumed", 32'(dma_pf_v_o), 32'h0);
    drain(3);

    // Duplicate filter
    n_saved = n_issued;
    step(1'b1, 32'h1000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1040, 1'b0, 1'b0, 1'b1);
    drain(10);
    chk("dup_issue_count", 32'(n_issued - n_saved), 32'd2);
    chk("dup_no_drops", 32'(drop_count_o), 32'h0);

    // Overflow with stalled DMA, then push+pop on a full FIFO
    for (int i = 0; i < 6; i++) step(1'b1, 32'h3000 + 32'(i * 64), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ovf_drop_one", 32'(drop_count_o), 32'h1);
    chk("ovf_issue_head", dma_pf_addr_o, 32'h3000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3400, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ovf_full_pushpop_no_drop", 32'(drop_count_o), 32'h1);
    chk("ovf_next_issue", dma_pf_addr_o, 32'h3040);
    drain(20);

    // Demand priority
    step(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("demand_blocks", 32'(dma_pf_v_o), 32'h0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("demand_release_issue", 32'(dma_pf_v_o), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("demand_no_retract", 32'(dma_pf_v_o), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drain(5);

    // Cool-down gap of 3
    gap_i = 4'd3;
    step(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4040, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !dma_pf_v_o; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("gap_first_v", 32'(dma_pf_v_o), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    yumi_edge = m_edge + 1;
    rise_edge = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (dma_pf_v_o) begin
        rise_edge = m_edge;
        break;
      end
    end
    chk("gap_rise_edges", 32'(rise_edge - yumi_edge), 32'd4);
    chk("gap_second_addr", dma_pf_addr_o, 32'h4040);
    drain(10);
    gap_i = 4'd0;

    // Flush during ISSUE with three queued
    for (int i = 0; i < 4; i++) step(1'b1, 32'h5000 + 32'(i * 64), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5100, 1'b0, 1'b1, 1'b0);
    n_saved = n_issued;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_req_kept", 32'(dma_pf_v_o), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_busy_after_yumi", 32'(busy_o), 32'h0);
    drain(5);
    chk("flush_no_more_issues", 32'(n_issued - n_saved), 32'h0);
    chk("flush_drops_unchanged", 32'(drop_count_o), 32'h1);

    // Asynchronous reset mid-ISSUE
    step(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("areset_pre_v", 32'(dma_pf_v_o), 32'h1);
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    chk("areset_v_immediate", 32'(dma_pf_v_o), 32'h0);
    chk("areset_busy_immediate", 32'(busy_o), 32'h0);
    chk("areset_drops_immediate", 32'(drop_count_o), 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    drain(2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      ra = 32'h8000 | (32'($urandom_range(0, 11)) << 6) | 32'($urandom_range(0, 63));
      step(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 30) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 50) == 0) gap_i = 4'($urandom_range(0, 3));
    end
    gap_i = 4'd0;
    drain(40);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    chk("final_idle", 32'(busy_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
